// File: rtl/sva_range_seq_gen.sv
// Stimulus generator for a |-> ##[MIN_DLY:MAX_DLY] b checkers: each accepted request
// emits one a_out pulse and one b_out pulse D cycles later, with D fixed, random or out-of-window.
module sva_range_seq_gen #(
    parameter int          MIN_DLY   = 1,
    parameter int          MAX_DLY   = 3,
    parameter int          CNT_W     = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] dly_in,
    output logic             ready,
    output logic             a_out,
    output logic             b_out,
    output logic [CNT_W-1:0] issued_dly,
    output logic             expect_pass,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] txn_count
);

    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_DLY);
    localparam logic [CNT_W-1:0] RANGE_C = CNT_W'(MAX_DLY - MIN_DLY + 1);
    localparam logic [CNT_W-1:0] EARLY_C = CNT_W'(MIN_DLY - 1);
    localparam logic [CNT_W-1:0] LATE_C  = CNT_W'(MAX_DLY + 1);

    typedef enum logic [1:0] {S_IDLE, S_ANT, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             pass_q, pass_d;
    logic             ready_q, ready_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             cfg_q, cfg_d;

    logic             req, reject, accept;
    logic [CNT_W-1:0] lfsr_lo;
    logic [CNT_W-1:0] new_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dly_q   <= '0;
            txn_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            pass_q  <= 1'b0;
            ready_q <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            txn_q   <= txn_d;
            lfsr_q  <= lfsr_d;
            pass_q  <= pass_d;
            ready_q <= ready_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cfg_q   <= cfg_d;
        end
    end

    // Pulse outputs are computed one cycle ahead so they come straight from flops.
    always_comb begin
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        lfsr_lo = CNT_W'(lfsr_q);

        unique case (mode)
            2'b00:   new_dly = dly_in;
            2'b01:   new_dly = MIN_C + (lfsr_lo % RANGE_C);
            2'b10:   new_dly = EARLY_C;
            default: new_dly = LATE_C;
        endcase

        req    = start && ready_q;
        reject = req && (mode == 2'b10) && (MIN_DLY == 0);
        accept = req && !reject;

        state_d = state_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        pass_d  = pass_q;
        a_d     = 1'b0;
        b_d     = 1'b0;
        cfg_d   = reject;
        txn_d   = b_q ? txn_q + CNT_W'(1) : txn_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ANT;
                    dly_d   = new_dly;
                    pass_d  = (int'(new_dly) >= MIN_DLY) && (int'(new_dly) <= MAX_DLY);
                    a_d     = 1'b1;
                    b_d     = (new_dly == '0);
                end
            end
            S_ANT: begin
                if (dly_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = dly_q - CNT_W'(1);
                    b_d     = (dly_q == CNT_W'(1));
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    b_d   = (cnt_q == CNT_W'(1));
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    assign ready       = ready_q;
    assign a_out       = a_q;
    assign b_out       = b_q;
    assign done        = b_q;
    assign cfg_err     = cfg_q;
    assign issued_dly  = dly_q;
    assign expect_pass = pass_q;
    assign txn_count   = txn_q;

endmodule

// File: tb/tb_sva_range_seq_gen.sv
// Self-checking bench for sva_range_seq_gen: table of directed transactions, random-mode
// sweep with a bound range-delay scoreboard, and hand sequences for reset and cfg_err.
module tb_sva_range_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start0;
    logic [1:0] mode, mode0;
    logic [7:0] dly_in, dly_in0;
    logic       ready, a_out, b_out, expect_pass, done, cfg_err;
    logic [7:0] issued_dly, txn_count;
    logic       ready0, a_out0, b_out0, expect_pass0, done0, cfg_err0;
    logic [7:0] issued_dly0, txn_count0;

    int checks = 0;
    int errors = 0;
    int chkPassCnt = 0, chkFailCnt = 0, expPassCnt = 0, expFailCnt = 0;

    always #5 clk = ~clk;

    sva_range_seq_gen #(.MIN_DLY(1), .MAX_DLY(3), .CNT_W(8), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dly_in(dly_in),
        .ready(ready), .a_out(a_out), .b_out(b_out), .issued_dly(issued_dly),
        .expect_pass(expect_pass), .done(done), .cfg_err(cfg_err), .txn_count(txn_count)
    );

    sva_range_seq_gen #(.MIN_DLY(0), .MAX_DLY(2), .CNT_W(8), .LFSR_SEED(16'hACE1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .dly_in(dly_in0),
        .ready(ready0), .a_out(a_out0), .b_out(b_out0), .issued_dly(issued_dly0),
        .expect_pass(expect_pass0), .done(done0), .cfg_err(cfg_err0), .txn_count(txn_count0)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] dly;
        int         expDly;
        bit         expPass;
    } vec_t;

    vec_t vecs[9];
    bit   seen[4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // One transaction on the MIN=1/MAX=3 instance; expDly < 0 means any value in the window.
    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] d, input int expDly,
                                 input bit expPass, input string tag, output int issuedOut);
        int waitCnt, aIdx, bIdx, aCount, bCount, cntBefore, obs;
        bit doneBad;
        waitCnt = 0;
        while (ready !== 1'b1 && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        issuedOut = -1;
        if (ready !== 1'b1) begin
            checkOutput({tag, " ready timeout"}, 32'(ready), 1);
            return;
        end
        cntBefore = int'(txn_count);
        mode   = m;
        dly_in = d;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        aIdx = -1; bIdx = -1; aCount = 0; bCount = 0; doneBad = 1'b0;
        for (int i = 1; i <= 300 && bIdx < 0; i++) begin
            if (a_out === 1'b1) begin
                aCount++;
                if (aIdx < 0) aIdx = i;
            end
            if (b_out === 1'b1) begin
                bCount++;
                bIdx = i;
            end
            if (done !== b_out) doneBad = 1'b1;
            if (bIdx < 0) @(negedge clk);
        end
        issuedOut = int'(issued_dly);
        obs = bIdx - aIdx;
        checkOutput({tag, " a_out cycle"}, aIdx, 1);
        checkOutput({tag, " b_out seen"}, 32'(bIdx > 0), 1);
        checkOutput({tag, " a_out count"}, aCount, 1);
        checkOutput({tag, " done with b_out"}, 32'(doneBad), 0);
        if (expDly >= 0) begin
            checkOutput({tag, " issued_dly"}, 32'(issued_dly), expDly);
            checkOutput({tag, " b delay"}, obs, expDly);
        end else begin
            checkOutput({tag, " issued in window"}, 32'(issued_dly >= 8'd1 && issued_dly <= 8'd3), 1);
            checkOutput({tag, " b delay"}, obs, int'(issued_dly));
        end
        checkOutput({tag, " expect_pass"}, 32'(expect_pass), 32'(expPass));
        if (obs >= 1 && obs <= 3 && bIdx > 0) chkPassCnt++;
        else chkFailCnt++;
        if (expect_pass === 1'b1) expPassCnt++;
        else expFailCnt++;
        @(negedge clk);
        checkOutput({tag, " ready after b"}, 32'(ready), 1);
        checkOutput({tag, " b_out low after"}, 32'(b_out), 0);
        checkOutput({tag, " txn_count"}, 32'(txn_count), (cntBefore + 1) % 256);
    endtask

    initial begin
        int issued;
        int nb;

        vecs[0] = '{2'b00, 8'd3,  3, 1'b1};
        vecs[1] = '{2'b11, 8'd1,  4, 1'b0};
        vecs[2] = '{2'b10, 8'd9,  0, 1'b0};
        vecs[3] = '{2'b00, 8'd0,  0, 1'b0};
        vecs[4] = '{2'b00, 8'd1,  1, 1'b1};
        vecs[5] = '{2'b00, 8'd2,  2, 1'b1};
        vecs[6] = '{2'b00, 8'd4,  4, 1'b0};
        vecs[7] = '{2'b00, 8'd10, 10, 1'b0};
        vecs[8] = '{2'b11, 8'd0,  4, 1'b0};

        rst_n = 1'b0; start = 1'b0; mode = 2'b00; dly_in = 8'd0;
        start0 = 1'b0; mode0 = 2'b00; dly_in0 = 8'd0;

        // Reset state and release timing
        repeat (3) @(negedge clk);
        checkOutput("reset ready", 32'(ready), 0);
        checkOutput("reset a_out", 32'(a_out), 0);
        checkOutput("reset b_out", 32'(b_out), 0);
        checkOutput("reset done", 32'(done), 0);
        checkOutput("reset cfg_err", 32'(cfg_err), 0);
        checkOutput("reset expect_pass", 32'(expect_pass), 0);
        checkOutput("reset issued_dly", 32'(issued_dly), 0);
        checkOutput("reset txn_count", 32'(txn_count), 0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready before first edge", 32'(ready), 0);
        @(negedge clk);
        checkOutput("ready after first edge", 32'(ready), 1);

        for (int i = 0; i < 9; i++)
            applyStimulus(vecs[i].mode, vecs[i].dly, vecs[i].expDly, vecs[i].expPass,
                          $sformatf("vec%0d", i), issued);

        // Random mode, back to back
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(2'b01, 8'd0, -1, 1'b1, "rnd", issued);
            if (issued >= 1 && issued <= 3) seen[issued] = 1'b1;
        end
        checkOutput("rnd hit 1", 32'(seen[1]), 1);
        checkOutput("rnd hit 2", 32'(seen[2]), 1);
        checkOutput("rnd hit 3", 32'(seen[3]), 1);
        checkOutput("checker pass count", chkPassCnt, expPassCnt);
        checkOutput("checker fail count", chkFailCnt, expFailCnt);

        // Start while busy is ignored, not queued
        mode = 2'b00; dly_in = 8'd2; start = 1'b1;
        @(negedge clk);
        checkOutput("busy a_out", 32'(a_out), 1);
        dly_in = 8'd7;
        @(negedge clk);
        checkOutput("busy b_out early", 32'(b_out), 0);
        @(negedge clk);
        checkOutput("busy b_out", 32'(b_out), 1);
        checkOutput("busy issued_dly", 32'(issued_dly), 2);
        start = 1'b0;
        @(negedge clk);
        checkOutput("busy ready", 32'(ready), 1);
        checkOutput("busy not queued", 32'(a_out), 0);

        // Reset during WAIT aborts the transaction
        mode = 2'b00; dly_in = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset ready", 32'(ready), 0);
        checkOutput("midreset issued_dly", 32'(issued_dly), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_out === 1'b1 || a_out === 1'b1) nb++;
        end
        checkOutput("midreset no pulses", nb, 0);
        checkOutput("midreset txn_count", 32'(txn_count), 0);
        checkOutput("midreset ready", 32'(ready), 1);

        // MIN_DLY=0 instance: D=2 in window, then rejected early mode
        mode0 = 2'b00; dly_in0 = 8'd2; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checkOutput("min0 a_out", 32'(a_out0), 1);
        checkOutput("min0 expect_pass", 32'(expect_pass0), 1);
        repeat (3) @(negedge clk);
        checkOutput("min0 ready", 32'(ready0), 1);
        mode0 = 2'b10; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checkOutput("min0 cfg_err", 32'(cfg_err0), 1);
        checkOutput("min0 no a_out", 32'(a_out0), 0);
        checkOutput("min0 ready stays", 32'(ready0), 1);
        checkOutput("min0 issued kept", 32'(issued_dly0), 2);
        @(negedge clk);
        checkOutput("min0 cfg_err pulse", 32'(cfg_err0), 0);
        checkOutput("min0 still no a_out", 32'(a_out0), 0);
        checkOutput("min0 txn_count", 32'(txn_count0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
